// File: rtl/rr_arb4_idx.sv
// Purpose : 4-requester round-robin arbiter, registered 2-bit grant index + valid.
// Latency : req sampled at edge N -> gnt_valid/gnt_idx valid right after edge N.
// Backpr. : owner holds the grant until done or req withdrawal; a 1-cycle bubble separates grants.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req[3:0]      level-sensitive requests, bit i = requester i
//   done          owner release pulse, only honoured while a grant is active
//   gnt_idx[1:0]  index of the current/last owner (feeds the downstream 2:4 decoder)
//   gnt_valid     grant active
//   busy_cnt[7:0] grant cycles elapsed in the current grant, saturating at 255
//   timeout_pulse one-cycle flag after a forced release (only with ARB_TIMEOUT_EN)
//
// Build option: define ARB_TIMEOUT_EN to cap every grant at MAX_HOLD cycles
// (MAX_HOLD legal range 1..255; ignored when the macro is not defined).

module rr_arb4_idx #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic [7:0] busy_cnt
`ifdef ARB_TIMEOUT_EN
   ,
   output logic       timeout_pulse
`endif
);

`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   // busy_cnt value on the last permitted grant cycle.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] gnt_idx_nxt;
   logic       gnt_valid_nxt;
   logic [7:0] busy_nxt;
   logic [1:0] pick_idx;
   logic [1:0] cand;
   logic       hit_limit;
   logic       release_now;

   // Rotating priority search: scan from ptr+3 down to ptr so the candidate
   // closest to ptr is written last and therefore wins.
   always_comb begin
      pick_idx = ptr;
      cand     = ptr;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (req[cand]) pick_idx = cand;
      end
   end

   // TO_EN folds the timeout away entirely in the default build.
   assign hit_limit   = TO_EN && (busy_cnt == HOLD_LAST);
   assign release_now = done || !req[gnt_idx] || hit_limit;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'b00;
         gnt_idx   <= 2'b00;
         gnt_valid <= 1'b0;
         busy_cnt  <= 8'h00;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt_idx   <= gnt_idx_nxt;
         gnt_valid <= gnt_valid_nxt;
         busy_cnt  <= busy_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req)       state_nxt = GRANT;
         GRANT:   if (release_now) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values. Releasing always passes through IDLE,
   // which is what produces the one-cycle gnt_valid bubble between grants.
   always_comb begin
      ptr_nxt       = ptr;
      gnt_idx_nxt   = gnt_idx;
      gnt_valid_nxt = 1'b0;
      busy_nxt      = busy_cnt;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_idx_nxt   = pick_idx;
               gnt_valid_nxt = 1'b1;
               busy_nxt      = 8'h00;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_nxt = gnt_idx + 2'd1;
            end else begin
               gnt_valid_nxt = 1'b1;
               if (busy_cnt != 8'hFF) busy_nxt = busy_cnt + 8'd1;
            end
         end
         default: ;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   // Flag only releases caused purely by the hold limit.
   logic forced_rel;
   assign forced_rel = (state == GRANT) && hit_limit && !done && req[gnt_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) timeout_pulse <= 1'b0;
      else     timeout_pulse <= forced_rel;
   end
`endif

endmodule

// File: tb/tb_rr_arb4_idx.sv
// Purpose : directed bench for rr_arb4_idx with a grant-order scoreboard.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : none; every step is a fixed number of clock cycles.

module tb_rr_arb4_idx;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic [7:0] busy_cnt;
`ifdef ARB_TIMEOUT_EN
   logic       timeout_pulse;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // Expected owner of each grant, in order.
   logic [1:0] exp_q[$];
   logic [1:0] cur_exp = 2'b00;
   bit         prev_vld = 1'b0;
   logic [3:0] dec;

   always #5 clk = ~clk;

   rr_arb4_idx #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .busy_cnt  (busy_cnt)
`ifdef ARB_TIMEOUT_EN
      ,
      .timeout_pulse (timeout_pulse)
`endif
   );

   // Downstream 2:4 decoder driven by gnt_idx.
   always_comb dec = 4'b0001 << gnt_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: pop the expected owner when a new grant appears and check
   // the decoded enable for every cycle the grant is held.
   always @(negedge clk) begin
      if (gnt_valid === 1'b1 && !prev_vld) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_grant", {30'd0, gnt_idx}, 32'hDEAD);
         end else begin
            cur_exp = exp_q.pop_front();
            chk("sb_grant_idx", {30'd0, gnt_idx}, {30'd0, cur_exp});
         end
      end
      if (gnt_valid === 1'b1)
         chk("sb_decoder", {28'd0, dec}, {28'd0, 4'b0001 << cur_exp});
      prev_vld = (gnt_valid === 1'b1);
   end

   initial begin
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      repeat (3) step();
      chk("reset_vld",  {31'd0, gnt_valid}, 32'd0);
      chk("reset_idx",  {30'd0, gnt_idx},   32'd0);
      chk("reset_busy", {24'd0, busy_cnt},  32'd0);
      rst = 1'b0;
      step();
      chk("idle_no_req", {31'd0, gnt_valid}, 32'd0);

      // Rotation with all requesters active.
      req = 4'b1111;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rot_vld", {31'd0, gnt_valid}, 32'd1);
         done = 1'b1;
         step();
         chk("rot_bubble", {31'd0, gnt_valid}, 32'd0);
         done = 1'b0;
      end
      req = 4'b0000;
      step();
      chk("rot_idle", {31'd0, gnt_valid}, 32'd0);

      // Wrap: grant 3, then 1001 goes to 0, then to 3.
      req = 4'b1000;
      exp_q.push_back(2'd3);
      step();
      chk("wrap_g3", {30'd0, gnt_idx}, 32'd3);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 4'b1001;
      exp_q.push_back(2'd0);
      step();
      chk("wrap_g0", {30'd0, gnt_idx}, 32'd0);
      done = 1'b1;
      step();
      done = 1'b0;
      exp_q.push_back(2'd3);
      step();
      chk("wrap_g3b", {30'd0, gnt_idx}, 32'd3);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 4'b0000;

      // Hold for 20 cycles, then withdraw.
      req = 4'b0010;
      exp_q.push_back(2'd1);
      step();
      chk("hold_start_busy", {24'd0, busy_cnt}, 32'd0);
      repeat (20) step();
      chk("hold_vld",  {31'd0, gnt_valid}, 32'd1);
      chk("hold_busy", {24'd0, busy_cnt},  32'd20);
      req = 4'b0000;
      step();
      chk("withdraw_vld", {31'd0, gnt_valid}, 32'd0);
      step();
      chk("withdraw_busy_kept", {24'd0, busy_cnt}, 32'd20);
      chk("withdraw_idx_kept",  {30'd0, gnt_idx},  32'd1);

      // ptr=2: owner 0, then done together with req[2] rising.
      req = 4'b0001;
      exp_q.push_back(2'd0);
      step();
      chk("simul_owner0", {30'd0, gnt_idx}, 32'd0);
      done = 1'b1;
      req  = 4'b0101;
      step();
      chk("simul_release", {31'd0, gnt_valid}, 32'd0);
      done = 1'b0;
      exp_q.push_back(2'd2);
      step();
      chk("simul_next_vld", {31'd0, gnt_valid}, 32'd1);
      chk("simul_next_idx", {30'd0, gnt_idx},   32'd2);
      chk("simul_busy_clr", {24'd0, busy_cnt},  32'd0);
      req = 4'b0000;
      step();

      // done while idle is ignored.
      done = 1'b1;
      step();
      chk("idle_done_vld", {31'd0, gnt_valid}, 32'd0);
      chk("idle_done_idx", {30'd0, gnt_idx},   32'd2);
      done = 1'b0;
      step();

      // Reset mid-grant acts without a clock edge (ptr=3 -> grant 1).
      req = 4'b0010;
      exp_q.push_back(2'd1);
      step();
      step();
      step();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_vld",  {31'd0, gnt_valid}, 32'd0);
      chk("async_rst_idx",  {30'd0, gnt_idx},   32'd0);
      chk("async_rst_busy", {24'd0, busy_cnt},  32'd0);
      req = 4'b0000;
      step();
      rst = 1'b0;
      req = 4'b0100;
      exp_q.push_back(2'd2);
      step();
      chk("post_rst_vld", {31'd0, gnt_valid}, 32'd1);
      chk("post_rst_idx", {30'd0, gnt_idx},   32'd2);
      req = 4'b0000;
      step();

      // Owner 0 holds forever; ptr=3 so 0011 picks 0 first.
      req = 4'b0001;
      exp_q.push_back(2'd0);
      step();
      req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
      repeat (3) step();
      chk("to_still_vld", {31'd0, gnt_valid},     32'd1);
      chk("to_pulse_lo",  {31'd0, timeout_pulse}, 32'd0);
      step();
      chk("to_forced_rel", {31'd0, gnt_valid},     32'd0);
      chk("to_pulse_hi",   {31'd0, timeout_pulse}, 32'd1);
      exp_q.push_back(2'd1);
      step();
      chk("to_next_idx",   {30'd0, gnt_idx},       32'd1);
      chk("to_pulse_done", {31'd0, timeout_pulse}, 32'd0);
`else
      repeat (10) step();
      chk("noto_vld",  {31'd0, gnt_valid}, 32'd1);
      chk("noto_idx",  {30'd0, gnt_idx},   32'd0);
      chk("noto_busy", {24'd0, busy_cnt},  32'd10);
`endif
      req = 4'b0000;
      step();
      step();
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rr_arb4_idx.md
Name: rr_arb4_idx

Overview:
- 4-requester round-robin arbiter producing a registered 2-bit grant index plus valid flag.
- Sits directly upstream of the 2:4 decoder: gnt_idx drives the decoder input, and the decoder's one-hot output becomes the per-requester grant enables.
- Holds a grant until the owner releases it, then rotates priority so no requester starves.

Parameters:
- MAX_HOLD, 8, maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request lines; bit i = requester i; level-sensitive
- done  input  1  owner release pulse; sampled only while gnt_valid=1
- gnt_idx  output  2  index of current owner, registered
- gnt_valid  output  1  grant active, registered
- busy_cnt  output  8  grant cycles elapsed in the current grant, saturating at 255

Behaviour:
- Reset (async assert, synchronous release to first clk edge) forces:
  - gnt_idx=2'b00, gnt_valid=0, busy_cnt=0
  - state=IDLE, priority pointer ptr=2'b00
- State IDLE:
  - If req != 0 at a clk edge, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register that index into gnt_idx, set gnt_valid=1, clear busy_cnt, go to GRANT.
  - If req == 0, stay in IDLE; gnt_idx holds its last value and gnt_valid=0.
- Latency: req sampled high at edge N gives gnt_valid=1 immediately after edge N. That is one clock of latency, with no combinational path from req to the outputs.
- State GRANT: the grant is released at an edge where either condition holds:
  - done=1, or
  - req[gnt_idx]=0 (owner withdrew)
- On release:
  - gnt_valid=0, ptr=gnt_idx+1 (2-bit wrap, so 3 -> 0), go to IDLE
  - gnt_idx keeps its value
  - busy_cnt keeps its value until the next grant
- While in GRANT with no release, busy_cnt increments by 1 per cycle, saturating at 8'hFF.
- Mandatory one-cycle bubble between consecutive grants (gnt_valid low for exactly 1 cycle). This keeps the downstream decoder's enable glitch-free.
- Simultaneous events:
  - done=1 while other requests are pending: release wins; the new arbitration happens on the next edge from IDLE using the updated ptr.
  - done=1 while gnt_valid=0: ignored.
  - Requests from non-owners during GRANT: ignored, no pre-emption.
- Reset mid-grant: outputs drop to reset values immediately (asynchronous), without waiting for a clock edge.
- gnt_idx is never X after reset. gnt_valid=1 implies req[gnt_idx] was 1 at the granting edge.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - In GRANT, when busy_cnt reaches MAX_HOLD-1 without a release, the next edge force-releases exactly as if done=1. ptr advances to gnt_idx+1.
  - A grant therefore lasts at most MAX_HOLD cycles.
  - An additional output timeout_pulse (1 bit, reset 0) is high for the one cycle following a forced release.
- Not defined:
  - No timeout; a grant persists until done or the owner withdraws.
  - The timeout_pulse port does not exist.
  - MAX_HOLD is unused.

Test Plan:
- Reset: assert rst=1 mid-simulation with gnt_valid=1 -> gnt_valid=0, gnt_idx=00, busy_cnt=0 before the next clk edge. Then req=4'b0100 -> gnt_idx=10, gnt_valid=1 one edge later.
- Rotation: req=4'b1111 held, done pulsed 1 cycle after each grant -> grant order 00,01,10,11,00. Each grant is separated by exactly one gnt_valid=0 cycle.
- Wrap and priority: after a grant to index 11 is released, req=4'b1001 -> next grant gnt_idx=00 (ptr wrapped). After that is released, the same req -> gnt_idx=11.
- Withdrawal and hold: grant idx 01, keep req[1]=1 with done=0 for 20 cycles -> gnt_valid stays 1 and busy_cnt=20. Drop req[1] -> gnt_valid=0 next edge.
- Simultaneous events:
  - done=1 in the same cycle req[2] rises while owner is 00 -> release, one idle cycle, then gnt_idx=10.
  - done=1 in IDLE -> no change.
- ARB_TIMEOUT_EN with MAX_HOLD=4: owner 00 holds forever -> forced release after 4 grant cycles, timeout_pulse=1 for one cycle. With req=4'b0011 the next grant is gnt_idx=01. Without the macro, the same stimulus keeps gnt_idx=00.
- Decoder pairing: connect gnt_idx to the 2:4 decoder -> decoder output equals 4'b0001<<gnt_idx whenever gnt_valid=1, across the rotation test.
